// File: rtl/mul_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_sequencer_pkg
// Description : Shared execute-stage encodings: ALU EXE_CMD values, status
//               register bit positions and the multiply sequencer states.
// Revision    : 1.0 - initial release
// ============================================================================
package mul_sequencer_pkg;

    // ALU command encodings (EXE_CMD)
    localparam logic [3:0] c_exe_nop = 4'b0000;
    localparam logic [3:0] c_exe_mov = 4'b0001;
    localparam logic [3:0] c_exe_mvn = 4'b1001;
    localparam logic [3:0] c_exe_add = 4'b0010;
    localparam logic [3:0] c_exe_adc = 4'b0011;
    localparam logic [3:0] c_exe_sub = 4'b0100;
    localparam logic [3:0] c_exe_sbc = 4'b0101;
    localparam logic [3:0] c_exe_and = 4'b0110;
    localparam logic [3:0] c_exe_orr = 4'b0111;
    localparam logic [3:0] c_exe_eor = 4'b1000;

    // Bit positions inside the {N,Z,C,V} status nibble
    localparam int c_sr_n = 3;
    localparam int c_sr_z = 2;
    localparam int c_sr_c = 1;
    localparam int c_sr_v = 0;

    // Mask of the status bits a multiply passes through untouched (C and V)
    localparam logic [3:0] c_sr_cv_mask = 4'b0011;

    // Sequencer states, explicitly encoded
    typedef enum logic [1:0] {
        c_st_idle = 2'd0,
        c_st_iter = 2'd1,
        c_st_done = 2'd2
    } mul_state_t;

endpackage : mul_sequencer_pkg
`default_nettype wire

// File: rtl/mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mul_sequencer
// Description : Multi-cycle MUL/MLA sequencer. Computes op_a*op_b (+op_acc)
//               by shift-and-add, borrowing the shared ALU for one ADD per
//               multiplier bit, then reports the product and N/Z update.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_sequencer
    import mul_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             accumulate,
    input  logic             set_flags,
    input  logic             flush,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] op_acc,
    input  logic [3:0]       SR_in,
    input  logic [WIDTH-1:0] alu_result,
    output logic             busy,
    output logic [3:0]       alu_cmd,
    output logic [WIDTH-1:0] alu_val1,
    output logic [WIDTH-1:0] alu_val2,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       status,
    output logic             status_we
);

    mul_state_t       r_state;
    mul_state_t       w_next_state;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic             r_set_flags;

    // Multiplier after this cycle's shift; zero means no more partial products
    logic [WIDTH-1:0] w_mplier_shifted;
    // A new operation is accepted only from IDLE and never alongside a flush
    logic             w_accept;
    // Status with fresh N/Z and C/V passed straight through from SR_in
    logic [3:0]       w_status;

    assign w_mplier_shifted = r_mplier >> 1;
    assign w_accept         = (r_state == c_st_idle) && start && !flush;
    assign w_status         = {r_acc[WIDTH-1], (r_acc == '0), 2'b00}
                            | (SR_in & c_sr_cv_mask);

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; flush overrides everything, including a start in IDLE
    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = c_st_idle;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        w_next_state = (op_b == '0) ? c_st_done : c_st_iter;
                    end
                end
                c_st_iter: begin
                    if (w_mplier_shifted == '0) begin
                        w_next_state = c_st_done;
                    end
                end
                c_st_done: begin
                    w_next_state = c_st_idle;
                end
                default: begin
                    w_next_state = c_st_idle;
                end
            endcase
        end
    end

    // Operand latch on accept, then one shift-and-add step per ITER cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_set_flags <= 1'b0;
        end else if (w_accept) begin
            r_mcand     <= op_a;
            r_mplier    <= op_b;
            r_acc       <= accumulate ? op_acc : '0;
            r_set_flags <= set_flags;
        end else if ((r_state == c_st_iter) && !flush) begin
            // Bits shifted out of the multiplicand are dropped (mod 2^WIDTH)
            r_acc    <= alu_result;
            r_mcand  <= r_mcand << 1;
            r_mplier <= w_mplier_shifted;
        end
    end

    // Output decode; done/status_we are masked by flush in the DONE cycle
    always_comb begin
        busy      = 1'b0;
        alu_cmd   = c_exe_nop;
        alu_val1  = '0;
        alu_val2  = '0;
        done      = 1'b0;
        result    = '0;
        status    = 4'b0000;
        status_we = 1'b0;
        case (r_state)
            c_st_iter: begin
                busy     = 1'b1;
                alu_cmd  = c_exe_add;
                alu_val1 = r_acc;
                alu_val2 = r_mplier[0] ? r_mcand : '0;
            end
            c_st_done: begin
                busy      = 1'b1;
                done      = !flush;
                result    = r_acc;
                status    = w_status;
                status_we = !flush && r_set_flags;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule : mul_sequencer
`default_nettype wire

// File: tb/tb_mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_sequencer
// Description : Self-checking bench for mul_sequencer with a behavioural ALU
//               and a product/latency reference computed from plain arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_sequencer;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             accumulate;
    logic             set_flags;
    logic             flush;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] op_acc;
    logic [3:0]       SR_in;
    logic [WIDTH-1:0] alu_result;
    logic             busy;
    logic [3:0]       alu_cmd;
    logic [WIDTH-1:0] alu_val1;
    logic [WIDTH-1:0] alu_val2;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [3:0]       status;
    logic             status_we;

    int n_vec = 0;
    int n_err = 0;

    mul_sequencer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .accumulate (accumulate),
        .set_flags  (set_flags),
        .flush      (flush),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_acc     (op_acc),
        .SR_in      (SR_in),
        .alu_result (alu_result),
        .busy       (busy),
        .alu_cmd    (alu_cmd),
        .alu_val1   (alu_val1),
        .alu_val2   (alu_val2),
        .done       (done),
        .result     (result),
        .status     (status),
        .status_we  (status_we)
    );

    // Combinational shared ALU: only ADD matters to the sequencer
    assign alu_result = (alu_cmd == 4'b0010) ? (alu_val1 + alu_val2) : '0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Every output at its quiescent value
    task automatic chk_idle(input string tag);
        chk({tag, ".busy"},      32'(busy),      32'd0);
        chk({tag, ".done"},      32'(done),      32'd0);
        chk({tag, ".status_we"}, 32'(status_we), 32'd0);
        chk({tag, ".alu_cmd"},   32'(alu_cmd),   32'd0);
        chk({tag, ".val1"},      alu_val1,       32'd0);
        chk({tag, ".val2"},      alu_val2,       32'd0);
        chk({tag, ".result"},    result,         32'd0);
        chk({tag, ".status"},    32'(status),    32'd0);
    endtask

    // Pulse start for one edge; called at a negedge, returns #1 after the edge
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                          input logic accum, input logic s, input logic [3:0] sr);
        op_a = a; op_b = b; op_acc = c; accumulate = accum; set_flags = s; SR_in = sr;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Full operation against the reference: per-ITER ALU traffic, latency,
    // result and status. noise pulses start mid-ITER and in the DONE cycle.
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic accum, input logic s,
                         input logic [3:0] sr, input logic noise);
        int          n;
        logic [31:0] base;
        logic [31:0] mask;
        logic [31:0] exp_res;
        n = 0;
        for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
        base    = accum ? c : 32'd0;
        exp_res = a * b + base;
        launch(a, b, c, accum, s, sr);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            mask = (k == 1) ? 32'd0 : ((32'd1 << (k - 1)) - 32'd1);
            chk({tag, ".iter_busy"}, 32'(busy),    32'd1);
            chk({tag, ".iter_done"}, 32'(done),    32'd0);
            chk({tag, ".iter_cmd"},  32'(alu_cmd), 32'h2);
            chk({tag, ".iter_val1"}, alu_val1,     base + a * (b & mask));
            chk({tag, ".iter_val2"}, alu_val2,     b[k-1] ? (a << (k - 1)) : 32'd0);
            if (noise && k == 2) begin
                op_a = $urandom; op_b = $urandom; start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
            end
        end
        @(negedge clk);
        chk({tag, ".done"},      32'(done),      32'd1);
        chk({tag, ".done_busy"}, 32'(busy),      32'd1);
        chk({tag, ".done_cmd"},  32'(alu_cmd),   32'd0);
        chk({tag, ".result"},    result,         exp_res);
        chk({tag, ".status"},    32'(status),    32'({exp_res[31], exp_res == 32'd0, sr[1], sr[0]}));
        chk({tag, ".status_we"}, 32'(status_we), 32'(s));
        if (noise) begin
            op_a = $urandom; op_b = 32'd1; start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        @(negedge clk);
        chk({tag, ".after_busy"}, 32'(busy), 32'd0);
        chk({tag, ".after_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; accumulate = 1'b0; set_flags = 1'b0; flush = 1'b0;
        op_a = '0; op_b = '0; op_acc = '0; SR_in = 4'b0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_idle("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle("idle");

        // Directed cases
        do_op("mul7x6",   32'd7,          32'd6,          32'd0, 1'b0, 1'b1, 4'b0000, 1'b0);
        do_op("mla_b0",   32'd9,          32'd0,          32'd5, 1'b1, 1'b0, 4'b0000, 1'b0);
        do_op("mul_ones", 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd0, 1'b0, 1'b0, 4'b0000, 1'b0);
        do_op("mla_msb",  32'h80000000,   32'd1,          32'd0, 1'b1, 1'b1, 4'b0010, 1'b0);
        do_op("noise",    32'd123,        32'h00000305,   32'd7, 1'b1, 1'b1, 4'b1101, 1'b1);
        do_op("b2b",      32'd11,         32'd13,         32'd0, 1'b0, 1'b1, 4'b0001, 1'b0);
        do_op("zero_res", 32'd0,          32'd5,          32'd0, 1'b0, 1'b1, 4'b0011, 1'b0);

        // Flush at ITER cycle 10 aborts with no done
        launch(32'h12345678, 32'hFFFF0000, 32'd0, 1'b0, 1'b1, 4'b0000);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        chk("flush.busy_pre", 32'(busy), 32'd1);
        @(posedge clk);
        #1 flush = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk_idle("flush");
        end

        // Reset in the middle of a second operation
        launch(32'h0000BEEF, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b1, 4'b0000);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk_idle("midreset");
        end
        do_op("after_abort", 32'd3, 32'd3, 32'd0, 1'b0, 1'b0, 4'b0000, 1'b0);

        // Start together with flush in IDLE is dropped
        flush = 1'b1;
        launch(32'd4, 32'd4, 32'd0, 1'b0, 1'b1, 4'b0000);
        flush = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk_idle("start_flush");
        end

        // Flush during the DONE cycle suppresses done and status_we
        launch(32'd1, 32'd0, 32'd8, 1'b1, 1'b1, 4'b0000);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_done.done", 32'(done),      32'd0);
        chk("flush_done.swe",  32'(status_we), 32'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk_idle("flush_done");

        // Randomized operations
        for (int t = 0; t < 40; t++) begin
            logic [31:0] ra, rb, rc;
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) rb = 32'd0;
            rc = $urandom;
            do_op("rand", ra, rb, rc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_mul_sequencer
`default_nettype wire

// File: doc/mul_sequencer.md
# mul_sequencer

Multi-cycle MUL/MLA sequencer for the execute stage. It performs 32×32→32 multiplication by shift-and-add, issuing one ADD per cycle to the shared ALU and taking the ALU result back. While it is busy, the pipeline is stalled and the ALU input mux is switched to this block. On completion it returns the product (plus accumulator for MLA) and the N/Z status update.

## Interface
Parameters:
- WIDTH, 32, operand/result width (ALU datapath width)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  request new multiply; sampled only in IDLE
- accumulate  in  1  1 = MLA (add op_acc), 0 = MUL
- set_flags  in  1  S bit; enables status update at completion
- flush  in  1  synchronous abort (pipeline flush)
- op_a  in  WIDTH  multiplicand (Rm)
- op_b  in  WIDTH  multiplier (Rs)
- op_acc  in  WIDTH  accumulator (Rn), used when accumulate=1
- SR_in  in  4  current {N,Z,C,V}
- alu_result  in  WIDTH  ALU_result returned from shared ALU
- busy  out  1  sequencer owns ALU; pipeline stall
- alu_cmd  out  4  EXE_CMD driven to ALU
- alu_val1  out  WIDTH  Val1 to ALU
- alu_val2  out  WIDTH  Val2 to ALU
- done  out  1  one-cycle completion pulse
- result  out  WIDTH  product, valid when done=1
- status  out  4  {N,Z,C,V} for status register, valid when done=1
- status_we  out  1  =done & latched set_flags

## Operation
- States: IDLE, ITER, DONE.
- IDLE, start=1:
  - latch mcand=op_a, mplier=op_b, acc=(accumulate ? op_acc : 0), set_flags.
  - Go to DONE if op_b==0, else ITER.
- ITER, each cycle:
  - alu_cmd=ADD (4'b0010), alu_val1=acc, alu_val2=(mplier[0] ? mcand : 0).
  - Next edge: acc←alu_result, mcand←mcand<<1, mplier←mplier>>1.
  - Go to DONE when the shifted mplier==0; otherwise stay.
- DONE:
  - done=1, result=acc.
  - status={acc[31], acc==0, SR_in.C, SR_in.V]; C and V are passed through unchanged.
  - status_we=set_flags.
  - Next state IDLE.
- Arithmetic: modulo 2^WIDTH; ALU carry/overflow ignored; mcand bits shifted out are dropped.
- Outside ITER: alu_cmd=4'b0000, alu_val1=alu_val2=0.
- busy=1 in ITER and DONE.
- start is ignored when not in IDLE (no queuing).
- flush=1 in any state: next state IDLE, no done, no status_we; flush has priority over start.
- Simultaneous start and flush in IDLE: start is dropped.

## Timing
- Reset values (rst_n low at an edge): state=IDLE, all registers 0, busy=0, done=0, status_we=0, result=0, status=0, alu_cmd=0, alu_val1=alu_val2=0.
- Reset mid-operation aborts like flush.
- n = index of the highest set bit of op_b plus 1 (n=0 if op_b==0).
- start accepted at edge E0: ITER occupies n cycles after E0, and done is high in cycle n+1 after E0.
- Minimum latency 1 cycle (op_b=0); maximum 33 cycles (op_b[31]=1).
- busy rises the cycle after E0 and falls the cycle after done; earliest next start is the cycle after done.
- The ALU is combinational: alu_result is used in the same cycle alu_cmd/val are driven.

## Structure
- Shared package (alongside the ALU encodings):
  - EXE_CMD constants: MOV 0001, MVN 1001, ADD 0010, ADC 0011, SUB 0100, SBC 0101, AND 0110, ORR 0111, EOR 1000.
  - Status bit indices N=3, Z=2, C=1, V=0.
  - mul_sequencer state enum.
- No sub-module. The ALU stays instantiated in the execute stage; the execute stage muxes its inputs on busy.
- Single FSM plus mcand/mplier/acc registers.

## Test plan
- MUL 7×6, S=1, SR_in=4'b0000: done 4 cycles after start, result=42, status=4'b0000, status_we=1.
- MLA op_b=0, op_acc=5, S=0: done 1 cycle after start, result=5, status_we=0, no ADD issued.
- MUL 0xFFFFFFFF×0xFFFFFFFF: 32 ADD cycles, done at cycle 33, result=0x00000001.
- MLA 0x80000000×1+0, S=1, SR_in=4'b0010: result=0x80000000, status=4'b1010.
- MUL 0x12345678×0xFFFF0000: flush at ITER cycle 10, then rst_n low during a second operation. Both abort with no done; outputs return to reset values; a following start of 3×3 gives result=9.
- start pulsed while busy and in the DONE cycle: ignored, first result unaffected. Back-to-back start the cycle after done is accepted.
